// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared receiver state encoding, legal parameter ranges and the
//            2-of-3 majority vote used for every bit decision.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame-walk states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Legal parameter ranges, checked at elaboration by the users
    localparam int c_CLK_DIV_MIN    = 1;
    localparam int c_OVERSAMPLE_MIN = 8;
    localparam int c_OVERSAMPLE_MAX = 32;
    localparam int c_DATA_BITS_MIN  = 5;
    localparam int c_DATA_BITS_MAX  = 9;
    localparam int c_STOP_BITS_MIN  = 1;
    localparam int c_STOP_BITS_MAX  = 2;

    // Two-of-three vote across the mid-bit samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Oversample prescaler. Emits a one-cycle tick every CLK_DIV
//            sysclk cycles; 'clear' restarts the count so the bit grid is
//            phase-aligned to the detected start edge.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 27
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < c_CLK_DIV_MIN) begin : g_chk_clk_div
            $error("uart_baud_tick: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;

    // Free-running divider, forced back to zero by clear or on wrap
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // A clear cycle never produces a tick, so the first tick after a
    // restart lands a full CLK_DIV cycles later.
    assign tick = !clear && (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parameterised oversampling UART receiver with 2-of-3 mid-bit
//            voting, optional parity, 1 or 2 checked stop bits and a single
//            holding register with ready/valid handshake and overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    generate
        if (CLK_DIV < c_CLK_DIV_MIN) begin : g_chk_clk_div
            $error("uart_rx_param: CLK_DIV must be at least 1");
        end
        if ((OVERSAMPLE < c_OVERSAMPLE_MIN) || (OVERSAMPLE > c_OVERSAMPLE_MAX) ||
            ((OVERSAMPLE % 2) != 0)) begin : g_chk_oversample
            $error("uart_rx_param: OVERSAMPLE must be even and within 8..32");
        end
        if ((DATA_BITS < c_DATA_BITS_MIN) || (DATA_BITS > c_DATA_BITS_MAX)) begin : g_chk_data_bits
            $error("uart_rx_param: DATA_BITS must be within 5..9");
        end
        if ((STOP_BITS < c_STOP_BITS_MIN) || (STOP_BITS > c_STOP_BITS_MAX)) begin : g_chk_stop_bits
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
        if ((PARITY_EN != 0) && (PARITY_EN != 1)) begin : g_chk_parity_en
            $error("uart_rx_param: PARITY_EN must be 0 or 1");
        end
        if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_chk_parity_odd
            $error("uart_rx_param: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_TCNT_W = $clog2(OVERSAMPLE);
    localparam int c_BIDX_W = 4;

    // Tick indices of the three mid-bit samples and of the last tick of a bit
    localparam logic [c_TCNT_W-1:0] c_IDX_S0   = c_TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TCNT_W-1:0] c_IDX_S1   = c_TCNT_W'(OVERSAMPLE / 2);
    localparam logic [c_TCNT_W-1:0] c_IDX_S2   = c_TCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_TCNT_W-1:0] c_IDX_LAST = c_TCNT_W'(OVERSAMPLE - 1);

    localparam logic [c_BIDX_W-1:0] c_LAST_DATA = c_BIDX_W'(DATA_BITS - 1);
    localparam logic [c_BIDX_W-1:0] c_LAST_STOP = c_BIDX_W'(STOP_BITS - 1);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx;

    uart_state_t          r_state;
    logic [c_TCNT_W-1:0]  r_tick_cnt;
    logic [c_BIDX_W-1:0]  r_bit_idx;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_armed;
    logic                 r_ferr_acc;
    logic                 r_perr_acc;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_ovr;

    logic                 w_tick;
    logic                 w_start_det;
    logic                 w_decide;
    logic                 w_bit_end;
    logic                 w_maj;
    logic                 w_done;
    logic                 w_frame_ferr;

    // Two-flop synchroniser on the asynchronous line, idling high
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // A start is only accepted once the line has been seen high since the
    // previous frame ended, so a line stuck low yields a single frame error.
    assign w_start_det = (r_state == ST_IDLE) && r_armed && !w_rx;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (w_start_det),
        .tick   (w_tick)
    );

    assign w_decide     = w_tick && (r_tick_cnt == c_IDX_S2);
    assign w_bit_end    = w_tick && (r_tick_cnt == c_IDX_LAST);
    assign w_maj        = majority3(r_s0, r_s1, w_rx);
    assign w_done       = (r_state == ST_STOP) && w_decide && (r_bit_idx == c_LAST_STOP);
    assign w_frame_ferr = r_ferr_acc | ~w_maj;

    // Tick position within the current bit, restarted on every start edge
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_start_det) begin
            r_tick_cnt <= '0;
        end else if ((r_state != ST_IDLE) && w_tick) begin
            if (r_tick_cnt == c_IDX_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
            end
        end
    end

    // Hold the first two mid-bit samples; the third is the live line value
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if ((r_state != ST_IDLE) && w_tick) begin
            if (r_tick_cnt == c_IDX_S0) begin
                r_s0 <= w_rx;
            end
            if (r_tick_cnt == c_IDX_S1) begin
                r_s1 <= w_rx;
            end
        end
    end

    // Frame walk: start validation, LSB-first shift, parity and stop checks
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_perr_acc <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx) begin
                        r_armed <= 1'b1;
                    end
                    if (w_start_det) begin
                        r_state    <= ST_START;
                        r_armed    <= 1'b0;
                        r_bit_idx  <= '0;
                        r_ferr_acc <= 1'b0;
                        r_perr_acc <= 1'b0;
                    end
                end

                ST_START: begin
                    // A high vote means the edge was noise: drop it quietly
                    if (w_decide && w_maj) begin
                        r_state <= ST_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_BIDX_W'(1);
                        end
                    end
                end

                ST_PARITY: begin
                    // Data XOR parity bit must equal the selected sense
                    if (w_decide) begin
                        r_perr_acc <= (^r_shift) ^ w_maj ^ c_PAR_ODD;
                    end
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_decide) begin
                        if (!w_maj) begin
                            r_ferr_acc <= 1'b1;
                        end
                        // Leave at mid-stop so a back-to-back start is seen
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_state   <= ST_IDLE;
                            r_bit_idx <= '0;
                        end
                    end
                    if (w_bit_end) begin
                        r_bit_idx <= r_bit_idx + c_BIDX_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: load on completion unless full and not being drained
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || rx_ready) begin
                r_data  <= r_shift;
                r_ferr  <= w_frame_ferr;
                r_perr  <= r_perr_acc;
                r_valid <= 1'b1;
                r_ovr   <= 1'b0;
            end else begin
                r_ovr   <= 1'b1;
            end
        end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_ferr;
    assign parity_err  = r_perr;
    assign overrun_err = r_ovr;

endmodule
`default_nettype wire
